// File: rtl/window_3x3.sv
// Raster-scan to 3x3 neighbourhood generator with two line buffers and registered taps.
// Define WIN_COORD_EN to add the o_row/o_col window-centre outputs.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module window_3x3 #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic                    i_sof,
    input  logic [`PIXEL_WIDTH-1:0] i_pixel,
    output logic [`PIXEL_WIDTH-1:0] o_p0,
    output logic [`PIXEL_WIDTH-1:0] o_p1,
    output logic [`PIXEL_WIDTH-1:0] o_p2,
    output logic [`PIXEL_WIDTH-1:0] o_p3,
    output logic [`PIXEL_WIDTH-1:0] o_p4,
    output logic [`PIXEL_WIDTH-1:0] o_p5,
    output logic [`PIXEL_WIDTH-1:0] o_p6,
    output logic [`PIXEL_WIDTH-1:0] o_p7,
    output logic [`PIXEL_WIDTH-1:0] o_p8,
`ifdef WIN_COORD_EN
    output logic [15:0]             o_row,
    output logic [15:0]             o_col,
`endif
    output logic                    o_valid
);

    localparam int PW = `PIXEL_WIDTH;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [15:0]   row;
    logic [15:0]   col;
    logic [15:0]   cur_row;
    logic [15:0]   cur_col;
    logic [15:0]   next_row;
    logic [15:0]   next_col;
    logic          win_valid;
    logic [CW-1:0] idx;
    logic [PW-1:0] a;
    logic [PW-1:0] b;

    logic [PW-1:0] lb0 [IMG_WIDTH];
    logic [PW-1:0] lb1 [IMG_WIDTH];

    // A start-of-frame pixel is placed at (0,0) regardless of the counters.
    always_comb begin
        cur_row   = i_sof ? 16'd0 : row;
        cur_col   = i_sof ? 16'd0 : col;
        idx       = cur_col[CW-1:0];
        a         = lb1[idx];
        b         = lb0[idx];
        win_valid = (cur_row >= 16'd2) && (cur_col >= 16'd2);
        next_row  = cur_row;
        next_col  = cur_col + 16'd1;
        if (cur_col == 16'(IMG_WIDTH - 1)) begin
            next_col = 16'd0;
            next_row = (cur_row == 16'(IMG_HEIGHT - 1)) ? 16'd0 : cur_row + 16'd1;
        end
    end

    // NOTE: line buffers have no reset; rows are always rewritten before they feed a valid window.
    always_ff @(posedge clk) begin
        if (!rst && i_valid) begin
            lb1[idx] <= b;
            lb0[idx] <= i_pixel;
        end
    end

    // NOTE: non-blocking updates let each tap shift take the previous cycle's neighbour value.
    always_ff @(posedge clk) begin
        if (rst) begin
            row     <= '0;
            col     <= '0;
            o_p0    <= '0;
            o_p1    <= '0;
            o_p2    <= '0;
            o_p3    <= '0;
            o_p4    <= '0;
            o_p5    <= '0;
            o_p6    <= '0;
            o_p7    <= '0;
            o_p8    <= '0;
            o_valid <= 1'b0;
`ifdef WIN_COORD_EN
            o_row   <= '0;
            o_col   <= '0;
`endif
        end else if (i_valid) begin
            row     <= next_row;
            col     <= next_col;
            o_p0    <= o_p1;
            o_p1    <= o_p2;
            o_p2    <= a;
            o_p3    <= o_p4;
            o_p4    <= o_p5;
            o_p5    <= b;
            o_p6    <= o_p7;
            o_p7    <= o_p8;
            o_p8    <= i_pixel;
            o_valid <= win_valid;
`ifdef WIN_COORD_EN
            o_row   <= cur_row - 16'd1;
            o_col   <= cur_col - 16'd1;
`endif
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule
